// File: rtl/control_ws_if.sv
// Handshake bundle between the multi-cycle controller and the CPU datapath/memory.
// The master side is the controller; the slave side is the datapath it steers.
interface control_ws_if #(
    parameter int OPC_W = 3
);
    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             mem_rdy;
    logic             resume;
    logic             rd;
    logic             wr;
    logic             ld_ir;
    logic             ld_ac;
    logic             ld_pc;
    logic             inc_pc;
    logic             halt;
    logic             data_e;
    logic             sel;
    logic             err;
    logic [3:0]       state;

    modport master (
        input  opcode, zero, mem_rdy, resume,
        output rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, err, state
    );

    modport slave (
        output opcode, zero, mem_rdy, resume,
        input  rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, err, state
    );
endinterface

// File: rtl/control_ws.sv
// Multi-cycle fetch/decode/execute controller with memory wait states, stall
// timeout fault and a resumable halt state.
module control_ws #(
    parameter int OPC_W = 3,
    parameter int TMO   = 15,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    control_ws_if.master bus
);
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    localparam int             TMO_LAST_I = (TMO > 0) ? TMO - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic is_hlt, is_skz, is_add, is_and, is_xor, is_lda, is_sto, is_jmp;
    logic is_alu, gated, stall, timeout;

    // Full-width compares so that any opcode above 7 matches nothing and acts as NOP.
    assign is_hlt = (bus.opcode == OPC_W'(0));
    assign is_skz = (bus.opcode == OPC_W'(1));
    assign is_add = (bus.opcode == OPC_W'(2));
    assign is_and = (bus.opcode == OPC_W'(3));
    assign is_xor = (bus.opcode == OPC_W'(4));
    assign is_lda = (bus.opcode == OPC_W'(5));
    assign is_sto = (bus.opcode == OPC_W'(6));
    assign is_jmp = (bus.opcode == OPC_W'(7));
    assign is_alu = is_add | is_and | is_xor | is_lda;

    assign gated   = (st == S_INST_FETCH) | ((st == S_OP_FETCH) & is_alu) |
                     ((st == S_STORE) & is_sto);
    assign stall   = gated & ~bus.mem_rdy;
    assign timeout = (TMO > 0) && stall && (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_INST_ADDR;
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (timeout) begin
            st    <= S_HALTED;
            cnt   <= '0;
            err_q <= 1'b1;
        end else if (stall) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
            case (st)
                S_INST_ADDR:  st <= S_INST_FETCH;
                S_INST_FETCH: st <= S_INST_LOAD;
                S_INST_LOAD:  st <= S_IDLE;
                S_IDLE:       st <= S_OP_ADDR;
                S_OP_ADDR:    st <= is_hlt ? S_HALTED : S_OP_FETCH;
                S_OP_FETCH:   st <= S_ALU_OP;
                S_ALU_OP:     st <= S_STORE;
                S_STORE:      st <= S_INST_ADDR;
                S_HALTED:     if (bus.resume && !err_q) st <= S_INST_ADDR;
                default:      st <= S_INST_ADDR;
            endcase
        end
    end

    always_comb begin
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.halt   = 1'b0;
        bus.data_e = 1'b0;
        bus.sel    = 1'b0;
        case (st)
            S_INST_ADDR: bus.sel = 1'b1;
            S_INST_FETCH: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                bus.inc_pc = 1'b1;
                bus.halt   = is_hlt;
            end
            S_OP_FETCH: bus.rd = is_alu;
            S_ALU_OP: begin
                bus.rd     = is_alu;
                bus.inc_pc = is_skz & bus.zero;
                bus.ld_pc  = is_jmp;
                bus.data_e = is_sto;
            end
            S_STORE: begin
                bus.rd     = is_alu;
                bus.ld_ac  = is_alu;
                bus.ld_pc  = is_jmp;
                bus.wr     = is_sto;
                bus.data_e = is_sto;
            end
            S_HALTED: bus.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = st;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_control_ws.sv
// Directed bench for control_ws: fetch/execute sequencing, wait states, timeout and halt/resume.
module tb_control_ws;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    control_ws_if #(.OPC_W(4)) bus ();

    control_ws #(.OPC_W(4), .TMO(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Strobe bits: rd wr ld_ir ld_ac ld_pc inc_pc halt data_e sel
    logic [8:0] strb;
    assign strb = {bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.ld_pc,
                   bus.inc_pc, bus.halt, bus.data_e, bus.sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.opcode  = 4'd2;
        bus.resume  = 1'b1;
        bus.mem_rdy = 1'b0;
        do_reset();
        bus.resume  = 1'b0;
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        n_checks++;
        if (strb !== 9'h001) begin
            n_fail++; $display("FAIL reset_strobes: got %h expected 001", strb);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err);
        end
    endtask

    task automatic test_add();
        logic [8:0] exp [8];
        exp = '{9'h001, 9'h101, 9'h141, 9'h141, 9'h008, 9'h100, 9'h100, 9'h120};
        bus.opcode  = 4'd2;
        bus.mem_rdy = 1'b1;
        bus.zero    = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.resume = (i == 1);
            n_checks++;
            if (bus.state !== 4'(i % 8) || strb !== exp[i % 8]) begin
                n_fail++;
                $display("FAIL add_cycle%0d: got state %0d strobes %h expected state %0d strobes %h",
                         i, bus.state, strb, i % 8, exp[i % 8]);
            end
            step();
        end
        bus.resume = 1'b0;
    endtask

    task automatic test_sto_stall();
        bus.opcode  = 4'd6;
        bus.mem_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (bus.state !== 4'd6 || strb !== 9'h002) begin
            n_fail++; $display("FAIL sto_s6: got state %0d strobes %h expected 6 002", bus.state, strb);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            bus.mem_rdy = (k == 3);
            n_checks++;
            if (bus.state !== 4'd7 || strb !== 9'h082) begin
                n_fail++;
                $display("FAIL sto_hold%0d: got state %0d strobes %h expected 7 082", k, bus.state, strb);
            end
            step();
        end
        n_checks++;
        if (bus.state !== 4'd0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL sto_exit: got state %0d err %b expected 0 0", bus.state, bus.err);
        end
    endtask

    task automatic test_hlt();
        bus.opcode  = 4'd0;
        bus.mem_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (bus.state !== 4'd4 || strb !== 9'h00C) begin
            n_fail++; $display("FAIL hlt_s4: got state %0d strobes %h expected 4 00c", bus.state, strb);
        end
        step();
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (bus.state !== 4'd8 || strb !== 9'h004) begin
                n_fail++;
                $display("FAIL hlt_hold%0d: got state %0d strobes %h expected 8 004", k, bus.state, strb);
            end
            step();
        end
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        n_checks++;
        if (bus.state !== 4'd0 || strb !== 9'h001) begin
            n_fail++; $display("FAIL hlt_resume: got state %0d strobes %h expected 0 001", bus.state, strb);
        end
    endtask

    task automatic test_timeout();
        bus.opcode  = 4'd2;
        bus.mem_rdy = 1'b0;
        do_reset();
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.state !== 4'd1 || bus.err !== 1'b0 || strb !== 9'h101) begin
                n_fail++;
                $display("FAIL tmo_stall%0d: got state %0d err %b strobes %h expected 1 0 101",
                         k, bus.state, bus.err, strb);
            end
            step();
        end
        n_checks++;
        if (bus.state !== 4'd8 || bus.err !== 1'b1 || strb !== 9'h004) begin
            n_fail++;
            $display("FAIL tmo_fault: got state %0d err %b strobes %h expected 8 1 004",
                     bus.state, bus.err, strb);
        end
        bus.resume  = 1'b1;
        bus.mem_rdy = 1'b1;
        step();
        bus.resume = 1'b0;
        step();
        n_checks++;
        if (bus.state !== 4'd8 || bus.err !== 1'b1) begin
            n_fail++; $display("FAIL tmo_resume: got state %0d err %b expected 8 1", bus.state, bus.err);
        end
        do_reset();
        n_checks++;
        if (bus.state !== 4'd0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_rst: got state %0d err %b expected 0 0", bus.state, bus.err);
        end
    endtask

    task automatic test_skz_jmp();
        logic [3:0] ops [3];
        logic       zs  [3];
        logic [8:0] exp [3][4];
        ops = '{4'd1, 4'd1, 4'd7};
        zs  = '{1'b1, 1'b0, 1'b0};
        exp = '{'{9'h008, 9'h000, 9'h008, 9'h000},
                '{9'h008, 9'h000, 9'h000, 9'h000},
                '{9'h008, 9'h000, 9'h010, 9'h010}};
        bus.mem_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.opcode = ops[c];
            bus.zero   = zs[c];
            do_reset();
            for (int i = 0; i < 4; i++) step();
            for (int s = 0; s < 4; s++) begin
                n_checks++;
                if (bus.state !== 4'(4 + s) || strb !== exp[c][s]) begin
                    n_fail++;
                    $display("FAIL skzjmp_c%0d_s%0d: got state %0d strobes %h expected %0d %h",
                             c, 4 + s, bus.state, strb, 4 + s, exp[c][s]);
                end
                step();
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_nop();
        logic [8:0] exp [8];
        exp = '{9'h001, 9'h101, 9'h141, 9'h141, 9'h008, 9'h000, 9'h000, 9'h000};
        bus.opcode  = 4'hA;
        bus.mem_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.mem_rdy = ((i % 8) < 4);
            n_checks++;
            if (bus.state !== 4'(i % 8) || strb !== exp[i % 8]) begin
                n_fail++;
                $display("FAIL nop_cycle%0d: got state %0d strobes %h expected state %0d strobes %h",
                         i, bus.state, strb, i % 8, exp[i % 8]);
            end
            step();
        end
    endtask

    task automatic test_rst_mid_stall();
        bus.opcode  = 4'd6;
        bus.mem_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        bus.mem_rdy = 1'b0;
        step();
        n_checks++;
        if (bus.state !== 4'd7) begin
            n_fail++; $display("FAIL rststall_pre: got state %0d expected 7", bus.state);
        end
        do_reset();
        n_checks++;
        if (bus.state !== 4'd0 || strb !== 9'h001 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL rststall_post: got state %0d strobes %h err %b expected 0 001 0",
                     bus.state, strb, bus.err);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.opcode  = 4'd0;
        bus.zero    = 1'b0;
        bus.mem_rdy = 1'b1;
        bus.resume  = 1'b0;
        test_reset();
        test_add();
        test_sto_stall();
        test_hlt();
        test_timeout();
        test_skz_jmp();
        test_nop();
        test_rst_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
